ad_top_ctrl: RTL and testbench



---
 rtl/ad_pkg.sv | 35 +++
 rtl/ad_bin2bcd_seq.sv | 60 ++++++
 rtl/ad_top_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_ad_top_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ad_pkg.sv
// ad_pkg: shared types, constants and helpers for the ADC128S022 display controller.
//   - ad_state_e : controller FSM states (GAP, XFER, SCALE, BCD)
//   - *_DEF      : default board parameters; HALF and K are derived from them
//   - FRAME_BITS : SCLK periods per conversion frame
//   - bcd_add3   : double-dabble digit correction
package ad_pkg;

    typedef enum logic [1:0] {
        GAP   = 2'd0,
        XFER  = 2'd1,
        SCALE = 2'd2,
        BCD   = 2'd3
    } ad_state_e;

    localparam int CLK_HZ_DEF  = 50_000_000;
    localparam int SCLK_HZ_DEF = 1_000_000;
    localparam int VREF_MV_DEF = 3300;
    localparam int GAP_CYC_DEF = 50;

    localparam int HALF       = CLK_HZ_DEF / (2 * SCLK_HZ_DEF);
    localparam int K          = VREF_MV_DEF / 10;
    localparam int FRAME_BITS = 16;

    // Add 3 to a BCD digit that is 5 or more so the following left shift carries correctly.
    function automatic logic [3:0] bcd_add3(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/ad_bin2bcd_seq.sv
// ad_bin2bcd_seq: sequential double-dabble converter, 10-bit binary to 3 BCD digits.
// The input is zero-extended to 12 bits and shifted 12 times.
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : begin a conversion of bin; ignored while a conversion is running
//   bin        : binary value (0..999)
//   done       : one-cycle pulse, bcd holds the finished result from that cycle on
//   bcd        : {hundreds, tens, units}
module ad_bin2bcd_seq
    import ad_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic        busy_r;
    logic [3:0]  cnt_r;
    logic [11:0] sh_r;
    logic [11:0] dig_r;
    logic        done_r;
    logic [11:0] adj_s;

    // Digit correction applied before every shift.
    always_comb begin
        adj_s = {bcd_add3(dig_r[11:8]), bcd_add3(dig_r[7:4]), bcd_add3(dig_r[3:0])};
    end

    // Conversion engine: load on start, then 12 correct-and-shift steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            cnt_r  <= 4'd0;
            sh_r   <= 12'h000;
            dig_r  <= 12'h000;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                {dig_r, sh_r} <= {adj_s[10:0], sh_r, 1'b0};
                cnt_r         <= cnt_r + 4'd1;
                if (cnt_r == 4'd11) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end else if (start) begin
                sh_r   <= {2'b00, bin};
                dig_r  <= 12'h000;
                cnt_r  <= 4'd0;
                busy_r <= 1'b1;
            end
        end
    end

    assign done = done_r;
    assign bcd  = dig_r;

endmodule

// File: rtl/ad_top_ctrl.sv
// ad_top_ctrl: SPI master for an ADC128S022-style 8-channel 12-bit ADC. Runs continuous
// frames on the channel picked by Switch, scales each result to volts (x.xx) and hands
// three packed BCD digits to the display.
//   CLK, Sys_RST : clock, asynchronous active-low reset
//   Switch       : channel select 0..3 (latched at the end of each gap)
//   SDI          : ADC DOUT
//   SCLK, CS, SDO: ADC serial clock (idles high), chip select (active low), ADC DIN
//   AD_Address   : {2'b00, ch} of the displayed value
//   AD_BCDOut    : {hundreds, tens, units}; hundreds digit is volts
// Build option: define AD_AVG_EN to average four frames per display update.
module ad_top_ctrl
    import ad_pkg::*;
#(
    parameter int CLK_HZ  = CLK_HZ_DEF,
    parameter int SCLK_HZ = SCLK_HZ_DEF,
    parameter int VREF_MV = VREF_MV_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
)
(
    input  logic        CLK,
    input  logic        Sys_RST,
    input  logic [1:0]  Switch,
    input  logic        SDI,
    output logic        SCLK,
    output logic        CS,
    output logic        SDO,
    output logic [3:0]  AD_Address,
    output logic [11:0] AD_BCDOut
);

    localparam int HALF_C  = CLK_HZ / (2 * SCLK_HZ);
    localparam int K_C     = VREF_MV / 10;
    localparam int PH_LAST = 2 * FRAME_BITS;

    ad_state_e   state_r, state_nxt_s;
    logic [15:0] cnt_r;
    logic [5:0]  ph_r;         // 0: lead-in, odd: SCLK low for bit ph/2, even: SCLK high
    logic [1:0]  ch_r;
    logic        first_r;
    logic        disc_r;
    logic [15:0] shreg_r;
    logic [11:0] sc_in_r;
    logic        sclk_r, cs_r, sdo_r;
    logic [11:0] bcd_out_r;
    logic [3:0]  addr_r;

    logic        gap_done_s, half_done_s, frame_end_s, upd_s;
    logic        cs_d_s, sclk_d_s, bcd_start_s, bcd_done_s;
    logic [15:0] din_s;
    logic [23:0] prod_s;
    logic [11:0] volts_full_s;
    logic [9:0]  volts_s;
    logic [11:0] bcd_s;

`ifdef AD_AVG_EN
    logic [13:0] acc_r;
    logic [1:0]  avg_cnt_r;
    logic [13:0] acc_sum_s;
    assign acc_sum_s = acc_r + {2'b00, 12'(shreg_r)};
    assign upd_s     = (avg_cnt_r == 2'd3);
`else
    assign upd_s     = 1'b1;
`endif

    assign gap_done_s  = (cnt_r == 16'(GAP_CYC - 1));
    assign half_done_s = (cnt_r == 16'(HALF_C - 1));
    assign frame_end_s = (state_r == XFER) && (ph_r == 6'(PH_LAST)) && half_done_s;
    // ADD2..ADD0 sit in DIN bits 13..11.
    assign din_s       = {2'b00, 1'b0, ch_r, 11'd0};

    // FSM state register.
    always_ff @(posedge CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            state_r <= GAP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            GAP: begin
                if (gap_done_s) state_nxt_s = XFER;
                else            state_nxt_s = GAP;
            end
            XFER: begin
                if (frame_end_s) begin
                    if (disc_r || !upd_s) state_nxt_s = GAP;
                    else                  state_nxt_s = SCALE;
                end else begin
                    state_nxt_s = XFER;
                end
            end
            SCALE: state_nxt_s = BCD;
            BCD: begin
                if (bcd_done_s) state_nxt_s = GAP;
                else            state_nxt_s = BCD;
            end
            default: state_nxt_s = GAP;
        endcase
    end

    // FSM outputs: next values of the ADC pins and the converter start strobe.
    always_comb begin
        cs_d_s      = 1'b1;
        sclk_d_s    = 1'b1;
        bcd_start_s = 1'b0;
        case (state_r)
            XFER: begin
                cs_d_s   = 1'b0;
                sclk_d_s = ~ph_r[0];
            end
            SCALE:   bcd_start_s = 1'b1;
            default: cs_d_s      = 1'b1;
        endcase
    end

    // Frame sequencing: gap/half-period counter, phase, channel latch, result capture.
    always_ff @(posedge CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            cnt_r     <= 16'd0;
            ph_r      <= 6'd0;
            ch_r      <= 2'b00;
            first_r   <= 1'b1;
            disc_r    <= 1'b1;
            sc_in_r   <= 12'h000;
`ifdef AD_AVG_EN
            acc_r     <= 14'd0;
            avg_cnt_r <= 2'd0;
`endif
        end else begin
            case (state_r)
                GAP: begin
                    ph_r <= 6'd0;
                    if (gap_done_s) begin
                        cnt_r   <= 16'd0;
                        ch_r    <= Switch;
                        // The ADC answers with the previous frame's channel, so a new
                        // channel (or the first frame) yields stale data.
                        disc_r  <= first_r | (Switch != ch_r);
                        first_r <= 1'b0;
`ifdef AD_AVG_EN
                        if (Switch != ch_r) begin
                            acc_r     <= 14'd0;
                            avg_cnt_r <= 2'd0;
                        end
`endif
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                XFER: begin
                    if (half_done_s) begin
                        cnt_r <= 16'd0;
                        ph_r  <= ph_r + 6'd1;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                    if (frame_end_s && !disc_r) begin
`ifdef AD_AVG_EN
                        if (avg_cnt_r == 2'd3) begin
                            sc_in_r   <= 12'(acc_sum_s >> 2);
                            acc_r     <= 14'd0;
                            avg_cnt_r <= 2'd0;
                        end else begin
                            acc_r     <= acc_sum_s;
                            avg_cnt_r <= avg_cnt_r + 2'd1;
                        end
`else
                        sc_in_r <= 12'(shreg_r);
`endif
                    end
                end
                default: begin
                    cnt_r <= 16'd0;
                    ph_r  <= 6'd0;
                end
            endcase
        end
    end

    // ADC pins: SDO changes on SCLK fall, SDI is shifted in on SCLK rise.
    always_ff @(posedge CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            cs_r    <= 1'b1;
            sclk_r  <= 1'b1;
            sdo_r   <= 1'b0;
            shreg_r <= 16'h0000;
        end else begin
            cs_r   <= cs_d_s;
            sclk_r <= sclk_d_s;
            if (sclk_r && !sclk_d_s) begin
                sdo_r <= din_s[~ph_r[4:1]];
            end
            if (!sclk_r && sclk_d_s) begin
                shreg_r <= {shreg_r[14:0], SDI};
            end
        end
    end

    // Scale to hundredths of a volt, rounded to nearest so a full-scale code reads 3.30.
    always_comb begin
        prod_s       = 24'(sc_in_r) * 24'(K_C) + 24'd2048;
        volts_full_s = 12'(prod_s >> 12);
        if (volts_full_s > 12'd999) begin
            volts_s = 10'd999;
        end else begin
            volts_s = volts_full_s[9:0];
        end
    end

    ad_bin2bcd_seq u_bcd (
        .clk   (CLK),
        .rst_n (Sys_RST),
        .start (bcd_start_s),
        .bin   (volts_s),
        .done  (bcd_done_s),
        .bcd   (bcd_s)
    );

    // Display registers: digits and channel change together, only on a finished conversion.
    always_ff @(posedge CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            bcd_out_r <= 12'h000;
            addr_r    <= 4'h0;
        end else if ((state_r == BCD) && bcd_done_s) begin
            bcd_out_r <= bcd_s;
            addr_r    <= {2'b00, ch_r};
        end
    end

    assign SCLK       = sclk_r;
    assign CS         = cs_r;
    assign SDO        = sdo_r;
    assign AD_Address = addr_r;
    assign AD_BCDOut  = bcd_out_r;

endmodule

// File: tb/tb_ad_top_ctrl.sv
// Directed bench for ad_top_ctrl with a behavioural ADC128S022 model
// (DIN sampled on SCLK rise, DOUT driven on SCLK fall, one-frame channel pipeline).
module tb_ad_top_ctrl;

    logic        CLK     = 1'b0;
    logic        Sys_RST = 1'b0;
    logic [1:0]  Switch  = 2'b00;
    logic        SDI     = 1'b0;
    logic        SCLK, CS, SDO;
    logic [3:0]  AD_Address;
    logic [11:0] AD_BCDOut;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] adc_val [0:7];

    // ADC model state
    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b1;
    logic [15:0] m_din     = 16'h0000;
    logic [15:0] m_word    = 16'h0000;
    logic [2:0]  m_next_ch = 3'd0;
    logic [2:0]  m_last_addr = 3'd0;
    int          m_rises = 0;
    int          m_falls = 0;
    int          m_last_rises = 0;

    always #10 CLK = ~CLK;

    ad_top_ctrl dut (
        .CLK        (CLK),
        .Sys_RST    (Sys_RST),
        .Switch     (Switch),
        .SDI        (SDI),
        .SCLK       (SCLK),
        .CS         (CS),
        .SDO        (SDO),
        .AD_Address (AD_Address),
        .AD_BCDOut  (AD_BCDOut)
    );

    // ADC model, edge-detected on the falling system clock edge.
    always @(negedge CLK) begin
        if (prev_cs && !CS) begin
            m_rises = 0;
            m_falls = 0;
            m_word  = {4'h0, adc_val[m_next_ch]};
        end else if (!prev_cs && CS) begin
            m_last_rises = m_rises;
            if (m_rises == 16) begin
                m_last_addr = m_din[13:11];
                m_next_ch   = m_din[13:11];
            end
        end
        if (!CS && prev_sclk && !SCLK && m_falls < 16) begin
            SDI     = m_word[15 - m_falls];
            m_falls = m_falls + 1;
        end
        if (!CS && !prev_sclk && SCLK) begin
            m_din   = {m_din[14:0], SDO};
            m_rises = m_rises + 1;
        end
        prev_cs   = CS;
        prev_sclk = SCLK;
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs(input logic lvl);
        int n;
        n = 0;
        while (CS !== lvl && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check("cs_wait", {11'd0, (CS === lvl)}, 12'd1);
    endtask

    task automatic frame();
        wait_cs(1'b0);
        wait_cs(1'b1);
        repeat (20) @(negedge CLK);
    endtask

    initial begin
        int n;
        int bad;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
        adc_val[0] = 12'hFFF;
        adc_val[2] = 12'h400;

        // Reset state
        repeat (5) @(negedge CLK);
        check("rst_sclk", {11'd0, SCLK}, 12'd1);
        check("rst_cs",   {11'd0, CS},   12'd1);
        check("rst_sdo",  {11'd0, SDO},  12'd0);
        check("rst_bcd",  AD_BCDOut,     12'h000);
        check("rst_addr", {8'd0, AD_Address}, 12'h000);

        // First frame: CS fall timing, SCLK lead-in and 16 pulses
        Sys_RST = 1'b1;
        n = 0;
        while (CS !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("cs_first_fall", {11'd0, (n >= 50 && n <= 52)}, 12'd1);
        n = 0;
        while (SCLK === 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("sclk_lead", 12'(n), 12'd25);
        bad = 0;
        for (int p = 0; p < 16; p++) begin
            n = 0;
            while (SCLK === 1'b0 && n < 100) begin
                @(negedge CLK);
                n++;
            end
            if (n != 25) bad++;
            n = 0;
            while (SCLK === 1'b1 && CS === 1'b0 && n < 100) begin
                @(negedge CLK);
                n++;
            end
            if (n != 25) bad++;
        end
        check("sclk_widths", 12'(bad), 12'd0);
        check("cs_end_frame", {11'd0, CS}, 12'd1);
        repeat (20) @(negedge CLK);
        check("f1_rises",   12'(m_last_rises), 12'd16);
        check("f1_din_add", {9'd0, m_last_addr}, 12'h000);
        check("f1_discard", AD_BCDOut, 12'h000);

        // Full, mid and zero scale on ch0
        frame();
        check("full_bcd",  AD_BCDOut, 12'h330);
        check("full_addr", {8'd0, AD_Address}, 12'h000);
        adc_val[0] = 12'h800;
        frame();
        check("mid_bcd", AD_BCDOut, 12'h165);
        adc_val[0] = 12'h000;
        frame();
        check("zero_bcd", AD_BCDOut, 12'h000);
        adc_val[0] = 12'hFFF;

        // Channel change 0 -> 2 during XFER
        wait_cs(1'b0);
        repeat (100) @(negedge CLK);
        Switch = 2'b10;
        wait_cs(1'b1);
        repeat (20) @(negedge CLK);
        check("chg_same_frame_bcd",  AD_BCDOut, 12'h330);
        check("chg_same_frame_addr", {8'd0, AD_Address}, 12'h000);
        frame();
        check("chg_din_add",     {9'd0, m_last_addr}, 12'h002);
        check("chg_discard_bcd", AD_BCDOut, 12'h330);
        check("chg_discard_addr", {8'd0, AD_Address}, 12'h000);
        frame();
        check("ch2_bcd",  AD_BCDOut, 12'h083);
        check("ch2_addr", {8'd0, AD_Address}, 12'h002);

        // Reset in the middle of a frame (around bit 7)
        wait_cs(1'b0);
        n = 0;
        while (m_falls < 8 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("mid_bit7_reached", {11'd0, (m_falls >= 8)}, 12'd1);
        repeat (5) @(negedge CLK);
        Sys_RST = 1'b0;
        #1;
        check("midrst_cs",   {11'd0, CS},   12'd1);
        check("midrst_sclk", {11'd0, SCLK}, 12'd1);
        check("midrst_bcd",  AD_BCDOut,     12'h000);
        check("midrst_addr", {8'd0, AD_Address}, 12'h000);
        repeat (3) @(negedge CLK);
        Sys_RST = 1'b1;
        frame();
        check("post_rst_rises",   12'(m_last_rises), 12'd16);
        check("post_rst_discard", AD_BCDOut, 12'h000);
        frame();
        check("post_rst_bcd",  AD_BCDOut, 12'h083);
        check("post_rst_addr", {8'd0, AD_Address}, 12'h002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
